// File: rtl/pc_gen.sv
// Program counter generator: selects the next PC from sequential/jump/trap sources,
// buffers a redirect that arrives during a stall, and flags misaligned targets.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter bit              VECTORED  = 1'b1,
  parameter int unsigned     CAUSE_W   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PC_WRITE,
  input  logic [2:0]         PC_SOURCE,
  input  logic [XLEN-1:0]    JALR,
  input  logic [XLEN-1:0]    BRANCH,
  input  logic [XLEN-1:0]    JAL,
  input  logic [XLEN-1:0]    MTVEC,
  input  logic [XLEN-1:0]    MEPC,
  input  logic               INTR_TAKEN,
  input  logic [CAUSE_W-1:0] CAUSE,
  output logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    PC_PLUS4,
  output logic               MISALIGN,
  output logic               REDIRECT_PEND
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pend_valid_q, pend_valid_d;
  logic            misalign_q;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] mtvec_base;
  logic            is_redirect;
  logic            is_misaligned;

  assign mtvec_base = {MTVEC[XLEN-1:2], 2'b00};
  assign PC_PLUS4   = pc_q + XLEN'(4);

  always_comb begin
    target = pc_q;
    unique case (PC_SOURCE)
      3'd1: target = {JALR[XLEN-1:1], 1'b0};
      3'd2: target = BRANCH;
      3'd3: target = JAL;
      3'd4: begin
        if (VECTORED && (MTVEC[1:0] == 2'b01) && INTR_TAKEN) begin
          target = mtvec_base + (XLEN'(CAUSE) << 2);
        end else begin
          target = mtvec_base;
        end
      end
      3'd5: target = MEPC;
      default: target = pc_q;
    endcase
  end

  assign is_redirect   = (PC_SOURCE >= 3'd1) && (PC_SOURCE <= 3'd5);
  // Only jump/branch targets can be misaligned; trap vectors and MEPC are trusted.
  assign is_misaligned = (PC_SOURCE >= 3'd1) && (PC_SOURCE <= 3'd3) && (target[1:0] != 2'b00);

  always_comb begin
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    if (is_misaligned) begin
      // Hold everything; the flag alone reports the fault.
    end else if (PC_WRITE) begin
      if (is_redirect) begin
        pc_d         = target;
        pend_valid_d = 1'b0;
      end else if (PC_SOURCE == 3'd0) begin
        pc_d         = pend_valid_q ? pend_addr_q : PC_PLUS4;
        pend_valid_d = 1'b0;
      end
    end else if (is_redirect) begin
      pend_addr_d  = target;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q         <= RESET_VEC;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      misalign_q   <= is_misaligned;
    end
  end

  assign PC            = pc_q;
  assign MISALIGN      = misalign_q;
  assign REDIRECT_PEND = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table stepped one clock per
// row, followed by a short hand-written misalignment pulse sequence.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic            PC_WRITE;
  logic [2:0]      PC_SOURCE;
  logic [XLEN-1:0] JALR, BRANCH, JAL, MTVEC, MEPC;
  logic            INTR_TAKEN;
  logic [4:0]      CAUSE;
  logic [XLEN-1:0] PC, PC_PLUS4;
  logic            MISALIGN, REDIRECT_PEND;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .XLEN     (32),
    .RESET_VEC(32'h0000_0000),
    .VECTORED (1'b1),
    .CAUSE_W  (5)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PC_WRITE     (PC_WRITE),
    .PC_SOURCE    (PC_SOURCE),
    .JALR         (JALR),
    .BRANCH       (BRANCH),
    .JAL          (JAL),
    .MTVEC        (MTVEC),
    .MEPC         (MEPC),
    .INTR_TAKEN   (INTR_TAKEN),
    .CAUSE        (CAUSE),
    .PC           (PC),
    .PC_PLUS4     (PC_PLUS4),
    .MISALIGN     (MISALIGN),
    .REDIRECT_PEND(REDIRECT_PEND)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [2:0]  src;
    logic [31:0] tgt;   // routed to the port selected by src
    logic        intr;
    logic [4:0]  cause;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic wr, input logic [2:0] src,
                     input logic [31:0] tgt, input logic intr, input logic [4:0] cause,
                     input logic [31:0] exp_pc, input logic exp_pend, input logic exp_mis);
    vec_t v;
    v.rst = rst; v.wr = wr; v.src = src; v.tgt = tgt; v.intr = intr; v.cause = cause;
    v.exp_pc = exp_pc; v.exp_pend = exp_pend; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [2:0] src,
                       input logic [31:0] tgt, input logic intr, input logic [4:0] cause);
    RST = rst; PC_WRITE = wr; PC_SOURCE = src; INTR_TAKEN = intr; CAUSE = cause;
    JALR = 32'h0; BRANCH = 32'h0; JAL = 32'h0; MTVEC = 32'h0; MEPC = 32'h0;
    case (src)
      3'd1: JALR = tgt;
      3'd2: BRANCH = tgt;
      3'd3: JAL = tgt;
      3'd4: MTVEC = tgt;
      3'd5: MEPC = tgt;
      default: ;
    endcase
  endtask

  initial begin
    //   rst  wr  src   target        intr cause  exp_pc        pend mis
    add(1, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0000, 0, 0); // reset
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0004, 0, 0);
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0008, 0, 0);
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_000C, 0, 0);
    add(0, 1, 3'd3, 32'h100,       0, 5'd0, 32'h0000_0100, 0, 0); // JAL to 0x100
    add(0, 0, 3'd3, 32'h200,       0, 5'd0, 32'h0000_0100, 1, 0); // buffered
    add(0, 0, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0100, 1, 0);
    add(0, 0, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0100, 1, 0);
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0200, 0, 0); // drain pending
    add(0, 1, 3'd4, 32'h1001,      1, 5'd7, 32'h0000_101C, 0, 0); // vectored intr
    add(0, 1, 3'd4, 32'h1001,      0, 5'd7, 32'h0000_1000, 0, 0); // exception
    add(0, 1, 3'd2, 32'h302,       0, 5'd0, 32'h0000_1000, 0, 1); // misaligned branch
    add(0, 1, 3'd1, 32'h301,       0, 5'd0, 32'h0000_0300, 0, 0); // JALR clears bit 0
    add(0, 1, 3'd5, 32'hFFFF_FFFC, 0, 5'd0, 32'hFFFF_FFFC, 0, 0); // MEPC
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0000, 0, 0); // wrap
    add(0, 1, 3'd6, 32'h0,         0, 5'd0, 32'h0000_0000, 0, 0); // illegal holds
    add(0, 0, 3'd2, 32'h40,        0, 5'd0, 32'h0000_0000, 1, 0);
    add(0, 0, 3'd1, 32'h83,        0, 5'd0, 32'h0000_0000, 1, 1); // misaligned in stall
    add(0, 0, 3'd5, 32'h500,       0, 5'd0, 32'h0000_0000, 1, 0); // overwrite pending
    add(0, 1, 3'd4, 32'h2001,      0, 5'd0, 32'h0000_2000, 0, 0); // live beats pending
    add(0, 0, 3'd3, 32'h700,       0, 5'd0, 32'h0000_2000, 1, 0);
    add(0, 1, 3'd7, 32'h0,         0, 5'd0, 32'h0000_2000, 1, 0); // illegal keeps pending
    add(1, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0000, 0, 0); // reset discards
    add(0, 1, 3'd0, 32'h0,         0, 5'd0, 32'h0000_0004, 0, 0);
    add(0, 1, 3'd4, 32'h3000,      1, 5'd3, 32'h0000_3000, 0, 0); // direct mode
    add(0, 1, 3'd4, 32'h4003,      1, 5'd3, 32'h0000_4000, 0, 0); // mode 11 -> base
    add(0, 1, 3'd4, 32'h0000_FFFD, 1, 5'd31, 32'h0001_0078, 0, 0); // vectored carry

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].src, vecs[i].tgt, vecs[i].intr, vecs[i].cause);
      @(posedge CLK);
      #1;
      check($sformatf("row%0d pc", i), PC, vecs[i].exp_pc);
      check($sformatf("row%0d pc_plus4", i), PC_PLUS4, vecs[i].exp_pc + 32'd4);
      check($sformatf("row%0d pend", i), {31'h0, REDIRECT_PEND}, {31'h0, vecs[i].exp_pend});
      check($sformatf("row%0d misalign", i), {31'h0, MISALIGN}, {31'h0, vecs[i].exp_mis});
    end

    // MISALIGN is a single-cycle pulse, raised even while stalled.
    drive(0, 0, 3'd3, 32'h0000_0102, 0, 5'd0);
    @(posedge CLK);
    #1;
    check("pulse high", {31'h0, MISALIGN}, 32'h1);
    check("pulse pc hold", PC, 32'h0001_0078);
    check("pulse no pend", {31'h0, REDIRECT_PEND}, 32'h0);
    drive(0, 0, 3'd0, 32'h0, 0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      check($sformatf("pulse low %0d", k), {31'h0, MISALIGN}, 32'h0);
      check($sformatf("stall pc %0d", k), PC, 32'h0001_0078);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001: Parameter XLEN, default 32, address width of every PC-related port.
- REQ-002: Parameter RESET_VEC, default 32'h0000_0000 (XLEN bits), PC value loaded on reset.
- REQ-003: Parameter VECTORED, default 1; 1 enables vectored trap mode, 0 forces direct mode.
- REQ-004: Parameter CAUSE_W, default 5, width of CAUSE.
- REQ-005: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-006: The ports SHALL be as follows:
  - CLK  in  1  clock.
  - RST  in  1  synchronous active-high reset.
  - PC_WRITE  in  1  advance enable; 0 = stall.
  - PC_SOURCE  in  3  next-PC select:
    - 0 = PC+4, 1 = JALR, 2 = BRANCH, 3 = JAL, 4 = MTVEC, 5 = MEPC.
    - 6 and 7 = illegal.
  - JALR, BRANCH, JAL, MTVEC, MEPC  in  XLEN each  candidate targets.
  - INTR_TAKEN  in  1  qualifies source 4 as an interrupt (vs. exception).
  - CAUSE  in  CAUSE_W  interrupt cause code.
  - PC  out  XLEN  current PC, registered.
  - PC_PLUS4  out  XLEN  PC+4, combinational, mod 2^XLEN.
  - MISALIGN  out  1  registered one-cycle pulse: misaligned control-transfer target.
  - REDIRECT_PEND  out  1  registered; a redirect is buffered during a stall.

Function
- REQ-007: The target SHALL be computed combinationally from PC_SOURCE:
  - JALR target = {JALR[XLEN-1:1],1'b0}.
  - BRANCH target = BRANCH; JAL target = JAL; MEPC target = MEPC.
- REQ-008: The MTVEC target SHALL be computed as follows:
  - Base = {MTVEC[XLEN-1:2],2'b00}.
  - If VECTORED=1, MTVEC[1:0]=2'b01 and INTR_TAKEN=1: target = base + (CAUSE<<2), mod 2^XLEN.
  - Otherwise: target = base.
- REQ-009: PC_SOURCE 1..5 SHALL be a redirect; 0 SHALL be sequential; 6 and 7 SHALL hold PC unchanged and SHALL NOT be a redirect.
- REQ-010: Misalignment SHALL be flagged for sources 1..3 with target[1:0]!=2'b00, regardless of PC_WRITE.
- REQ-011: On a flagged misalignment:
  - PC and the pending buffer are unchanged.
  - MISALIGN = 1 in the next cycle only.
- REQ-012: On PC_WRITE=1 with a legal, non-misaligned redirect: PC <= target and the pending buffer is cleared, so a live redirect beats a pending one.
- REQ-013: On PC_WRITE=1, PC_SOURCE=0 and pending valid: PC <= pending address and pending is cleared.
- REQ-014: On PC_WRITE=1, PC_SOURCE=0 and no pending: PC <= PC+4, wrapping mod 2^XLEN.
- REQ-015: On PC_WRITE=0 with a legal, non-misaligned redirect: PC holds, pending address <= target, pending valid <= 1; a newer redirect overwrites an older pending one.
- REQ-016: On PC_WRITE=0 without a redirect: PC and the pending state SHALL hold.
- REQ-017: REDIRECT_PEND SHALL equal the pending-valid register.
- REQ-018: Latency SHALL be as follows:
  - A redirect accepted with PC_WRITE=1 in cycle N appears on PC in cycle N+1.
  - A buffered redirect appears in the cycle after the first PC_WRITE=1 with PC_SOURCE=0.

Reset
- REQ-019: On a rising CLK edge with RST=1: PC <= RESET_VEC, pending valid <= 0, pending address <= 0, MISALIGN <= 0.
- REQ-020: RST SHALL take priority over all other inputs, including mid-stall with a pending redirect, which is discarded.
- REQ-021: PC_PLUS4 SHALL read RESET_VEC+4 in the first cycle after reset.

Verification
- REQ-022: Reset release, then 3 cycles PC_WRITE=1, PC_SOURCE=0 -> PC = 0x0, 0x4, 0x8, 0xC.
- REQ-023: Stall buffer test:
  - PC=0x100, PC_WRITE=0, PC_SOURCE=3, JAL=0x200 for 1 cycle -> REDIRECT_PEND=1, PC=0x100.
  - 2 further stall cycles with PC_SOURCE=0 -> PC=0x100.
  - PC_WRITE=1, PC_SOURCE=0 -> PC=0x200, REDIRECT_PEND=0.
- REQ-024: Vectored trap test: MTVEC=0x0000_1001, INTR_TAKEN=1, CAUSE=7, PC_SOURCE=4, PC_WRITE=1 -> PC=0x101C; same with INTR_TAKEN=0 -> PC=0x1000.
- REQ-025: Misalignment test:
  - BRANCH=0x302, PC_SOURCE=2, PC_WRITE=1 -> PC unchanged, MISALIGN=1 for exactly one cycle.
  - JALR=0x301 -> PC=0x300, MISALIGN=0.
- REQ-026: Wrap test: PC=0xFFFF_FFFC, PC_SOURCE=0, PC_WRITE=1 -> PC=0x0.
- REQ-027: Illegal-select and reset-priority test:
  - PC_SOURCE=6 with PC_WRITE=1 -> PC holds.
  - Pending valid, then RST=1 -> PC=RESET_VEC, REDIRECT_PEND=0.
